// File: rtl/serial_twos_complement_pkg.sv
// Shared types for the digit-serial two's-complement unit: mode encodings,
// FSM states and the invert-decision helper.
package serial_twos_complement_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Reserved mode falls through to PASS because it matches neither arm.
  function automatic logic needs_invert(input logic [1:0] mode, input logic sign);
    return (mode == MODE_NEG) || ((mode == MODE_ABS) && sign);
  endfunction

endpackage

// File: rtl/serial_twos_complement_chunk_incrementer.sv
// One W-bit stage of the serial negator: optional bitwise invert followed by
// a carry-in increment; the carry-out feeds the next chunk through a flop.
module chunk_incrementer #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic         invert,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] operand;

  always_comb begin
    operand     = invert ? ~a : a;
    {cout, sum} = {1'b0, operand} + (W+1)'(cin);
  end

endmodule

// File: rtl/serial_twos_complement.sv
// Digit-serial negate / absolute-value / pass unit: processes W bits per
// clock LSB first, carrying between chunks through a registered carry.
module serial_twos_complement
  import serial_twos_complement_pkg::*;
#(
  parameter int N = 24,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf,
  output logic         out_zero
);

  localparam int CHUNKS = N / W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CHUNKS - 1);
  localparam logic [N-1:0]     MIN_NEG = N'(1) << (N - 1);

  state_e           state;
  logic [N-1:0]     op_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             invert;
  logic             ovf_pend;
  logic [W-1:0]     sum;
  logic             cout;
  logic [N-1:0]     next_res;
  logic             accept_invert;

  chunk_incrementer #(.W(W)) u_inc (
    .a      (op_sr[W-1:0]),
    .invert (invert),
    .cin    (carry),
    .sum    (sum),
    .cout   (cout)
  );

  // Result is assembled in place in out_data; it is only qualified by out_valid.
  always_comb begin
    next_res = out_data;
    next_res[cnt*W +: W] = sum;
    accept_invert = needs_invert(in_mode, in_data[N-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      op_sr     <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      invert    <= 1'b0;
      ovf_pend  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_sr    <= in_data;
            invert   <= accept_invert;
            carry    <= accept_invert;
            ovf_pend <= accept_invert && (in_data == MIN_NEG);
            cnt      <= '0;
            in_ready <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          out_data <= next_res;
          carry    <= cout;
          op_sr    <= op_sr >> W;
          if (cnt == LAST) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            out_ovf   <= ovf_pend;
            out_zero  <= (next_res == '0);
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_twos_complement.sv
// Bench for serial_twos_complement: directed cases plus random operands on
// four instances (W = 8, 1, 4, 24) against an arithmetic reference model.
module tb_serial_twos_complement;

  localparam int N = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid  [4];
  logic            in_ready  [4];
  logic [N-1:0]    in_data   [4];
  logic [1:0]      in_mode   [4];
  logic            out_valid [4];
  logic            out_ready [4];
  logic [N-1:0]    out_data  [4];
  logic            out_ovf   [4];
  logic            out_zero  [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int w_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 1 : (d == 2) ? 4 : 24;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_twos_complement #(.N(N), .W((g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 24)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_mode   (in_mode[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_ovf   (out_ovf[g]),
      .out_zero  (out_zero[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: negate when mode is NEG, or ABS of a negative operand.
  task automatic ref_model(input logic [N-1:0] data, input logic [1:0] mode,
                           output logic [N-1:0] res, output logic ovf, output logic zero);
    logic inv;
    longint unsigned neg;
    inv  = (mode == 2'b01) || (mode == 2'b10 && data[N-1]);
    neg  = (64'd1 << N) - longint'(data);
    res  = inv ? neg[N-1:0] : data;
    ovf  = inv && (data == 24'h800000);
    zero = (res == '0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int d, input logic [N-1:0] data, input logic [1:0] mode, input string tag);
    int guard;
    guard = 0;
    while (!in_ready[d] && guard < 200) begin
      tick();
      guard++;
    end
    check({tag, ".ready"}, 32'(in_ready[d]), 32'd1);
    in_data[d]  = data;
    in_mode[d]  = mode;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    in_data[d]  = N'($urandom);
    in_mode[d]  = 2'($urandom);
  endtask

  task automatic wait_result(input int d, input logic [N-1:0] data, input logic [1:0] mode, input string tag);
    int lat;
    logic [N-1:0] er;
    logic eo, ez;
    ref_model(data, mode, er, eo, ez);
    lat = 0;
    while (!out_valid[d] && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, ".lat"},  32'(lat), 32'(N / w_of(d)));
    check({tag, ".data"}, 32'(out_data[d]), 32'(er));
    check({tag, ".ovf"},  32'(out_ovf[d]), 32'(eo));
    check({tag, ".zero"}, 32'(out_zero[d]), 32'(ez));
  endtask

  task automatic release_out(input int d, input string tag);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check({tag, ".vld_clr"}, 32'(out_valid[d]), 32'd0);
    check({tag, ".rdy_set"}, 32'(in_ready[d]), 32'd1);
  endtask

  task automatic run_op(input int d, input logic [N-1:0] data, input logic [1:0] mode, input string tag);
    accept(d, data, mode, tag);
    wait_result(d, data, mode, tag);
    release_out(d, tag);
  endtask

  task automatic check_reset_state(input int d, input string tag);
    check({tag, ".out_valid"}, 32'(out_valid[d]), 32'd0);
    check({tag, ".in_ready"},  32'(in_ready[d]), 32'd1);
    check({tag, ".out_data"},  32'(out_data[d]), 32'd0);
    check({tag, ".out_ovf"},   32'(out_ovf[d]), 32'd0);
    check({tag, ".out_zero"},  32'(out_zero[d]), 32'd0);
  endtask

  initial begin
    logic [N-1:0] held;
    logic [N-1:0] rdata;
    logic [1:0]   rmode;

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_mode[i]   = '0;
      out_ready[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) check_reset_state(i, $sformatf("reset%0d", i));

    // Directed cases on the W=8 instance
    run_op(0, 24'h000001, 2'b01, "neg_one");
    run_op(0, 24'h800000, 2'b01, "neg_min");
    run_op(0, 24'h000000, 2'b01, "neg_zero");
    run_op(0, 24'hFFFFF6, 2'b10, "abs_neg");
    run_op(0, 24'h00000A, 2'b10, "abs_pos");
    run_op(0, 24'h123456, 2'b00, "pass");
    run_op(0, 24'h987654, 2'b11, "rsvd");
    run_op(0, 24'h800000, 2'b10, "abs_min");
    run_op(0, 24'h800000, 2'b00, "pass_min");

    // Backpressure: result held, new operands refused while DONE
    accept(0, 24'h00ABCD, 2'b01, "bp");
    wait_result(0, 24'h00ABCD, 2'b01, "bp");
    held = 24'hFF5433;
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = i[0];
      in_data[0]  = N'($urandom);
      in_mode[0]  = 2'b01;
      tick();
      check($sformatf("bp_data%0d", i), 32'(out_data[0]), 32'(held));
      check($sformatf("bp_rdy%0d", i),  32'(in_ready[0]), 32'd0);
      check($sformatf("bp_vld%0d", i),  32'(out_valid[0]), 32'd1);
    end
    in_valid[0] = 1'b0;
    release_out(0, "bp");
    run_op(0, 24'h000005, 2'b01, "bp_next");

    // Reset during the second BUSY cycle discards the partial result
    accept(0, 24'h123456, 2'b01, "rst_mid");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state(0, "rst_mid");
    tick();
    check("rst_mid.no_valid", 32'(out_valid[0]), 32'd0);
    run_op(0, 24'h000002, 2'b01, "after_rst");

    // Random sweep across all chunk widths, including boundary operands
    for (int d = 0; d < 4; d++) begin
      run_op(d, 24'h800000, 2'b01, $sformatf("w%0d_min", w_of(d)));
      run_op(d, 24'h000000, 2'b01, $sformatf("w%0d_zero", w_of(d)));
      for (int k = 0; k < 16; k++) begin
        rdata = N'($urandom);
        rmode = 2'($urandom);
        if (k % 5 == 0) rdata = {rdata[N-1], {(N-1){1'b1}}};
        run_op(d, rdata, rmode, $sformatf("w%0d_r%0d", w_of(d), k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
